sift_win3x3_gen: RTL

- Downstream consumer of the 8-bit pixel FIFO. Pops raster-order grey pixels from it and keeps two internal line buffers.
- Emits every interior 3x3 neighbourhood with its centre coordinates, for the SIFT Gaussian/DoG stage.
- Drives the FIFO's rd_en and honours the FIFO's 1-cycle registered read latency.
- Output side is a valid/ready handshake with full backpressure.

---
 rtl/sift_win3x3_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sift_win3x3_gen.sv
// 3x3 sliding-window generator: pops raster pixels from a 1-cycle-latency FIFO and emits interior windows.
// Optional backpressure counter enabled by defining SIFT_WIN_STALL_CNT_EN.
module sift_win3x3_gen #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_dout,
    output logic                fifo_rd_en,
    output logic [71:0]         win,
    output logic [COL_BITS-1:0] win_x,
    output logic [ROW_BITS-1:0] win_y,
    output logic                win_valid,
    input  logic                win_ready,
    output logic                busy,
    output logic                frame_done,
    output logic [31:0]         stall_cnt
);
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int REQ_BITS = $clog2(NPIX + 1);
    localparam logic [REQ_BITS-1:0] NPIX_V = REQ_BITS'(NPIX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [REQ_BITS-1:0] req_cnt;
    logic                inflight;
    logic [1:0]          skid_cnt;
    logic [7:0]          skid0, skid1;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [7:0]          lb1 [IMG_W];
    logic [7:0]          lb2 [IMG_W];
    logic [7:0]          top0, top1, mid0, mid1, bot0, bot1;

    logic       head_vld, consume, from_skid, bypass, accept, last_acc, room, emit;
    logic [7:0] head, top_px, mid_px;
    logic [1:0] keep;

    always_comb begin
        head_vld  = (skid_cnt != 2'd0) || inflight;
        head      = (skid_cnt != 2'd0) ? skid0 : fifo_dout;
        consume   = (state == RUN) && head_vld && (!win_valid || win_ready);
        from_skid = consume && (skid_cnt != 2'd0);
        bypass    = consume && (skid_cnt == 2'd0);
        keep      = skid_cnt - {1'b0, from_skid};
        accept    = win_valid && win_ready;
        last_acc  = accept && (win_x == COL_BITS'(IMG_W - 2)) && (win_y == ROW_BITS'(IMG_H - 2));
        // A slot freed by this cycle's consume is usable by the read issued now.
        room      = ({1'b0, skid_cnt} + {2'b00, inflight}) <= (3'd1 + {2'b00, consume});
        fifo_rd_en = (state == RUN) && !fifo_empty && (req_cnt < NPIX_V) && room;
        emit      = consume && (col >= COL_BITS'(2)) && (row >= ROW_BITS'(2));
        top_px    = lb2[col];
        mid_px    = lb1[col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_cnt    <= '0;
            inflight   <= 1'b0;
            skid_cnt   <= 2'd0;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win        <= '0;
            win_x      <= '0;
            win_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            skid_cnt <= keep + {1'b0, inflight && !bypass};
            if (fifo_rd_en)
                req_cnt <= req_cnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    req_cnt <= '0;
                    col     <= '0;
                    row     <= '0;
                end
                RUN: if (last_acc) begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                end
            endcase
            if (consume) begin
                if (col == COL_BITS'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_BITS'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (emit) begin
                win_valid <= 1'b1;
                win       <= {head, bot1, bot0, mid_px, mid1, mid0, top_px, top1, top0};
                win_x     <= col - COL_BITS'(1);
                win_y     <= row - ROW_BITS'(1);
            end else if (accept) begin
                win_valid <= 1'b0;
            end
        end
    end

    // Datapath storage: skid entries, line buffers and column history need no reset.
    always_ff @(posedge clk) begin
        if (from_skid)
            skid0 <= skid1;
        if (inflight && !bypass) begin
            if (keep == 2'd0)
                skid0 <= fifo_dout;
            else
                skid1 <= fifo_dout;
        end
        if (consume) begin
            lb2[col] <= mid_px;
            lb1[col] <= head;
            top0 <= top1;
            top1 <= top_px;
            mid0 <= mid1;
            mid1 <= mid_px;
            bot0 <= bot1;
            bot1 <= head;
        end
    end

`ifdef SIFT_WIN_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (state == IDLE && start)
            stall_q <= '0;
        else if (state == RUN && win_valid && !win_ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 1'b1;
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
